bus_glue_bridge: RTL and testbench
==================================

# bus_glue_bridge

Registered single-clock bridge between a parent local bus (`i_*`) and a child local bus (`o_*`). It forwards writes and reads from the parent address space into a child address window and returns child read data to the parent. It also forwards the clock to the child side. The block sits where a sub-bus hangs off the main bus, giving the child tree a contiguous window with address trimming and strobe gating.

## Interface
- `AW`, 24, address width of both buses.
- `DW`, 32, data width of both buses.
- `CHILD_AW`, 22, child window size is 2^CHILD_AW words; 1 ≤ CHILD_AW ≤ AW.
- `BASE`, 0, parent base address of the child window; must be aligned to 2^CHILD_AW, and its low CHILD_AW bits are ignored.

Ports:
- `i_clk`  input  1  sole clock; one clock domain, all logic on its rising edge.
- `i_rst`  input  1  synchronous, active-high reset.
- `i_addr`  input  AW  parent address.
- `i_wdata`  input  DW  parent write data.
- `i_wstb`  input  1  parent write strobe, one cycle per write.
- `i_rdata`  output  DW  parent read data.
- `o_clk`  output  1  child clock, combinational copy of `i_clk`.
- `o_addr`  output  AW  child address, registered.
- `o_wdata`  output  DW  child write data, registered.
- `o_rdata`  input  DW  child read data; the child registers it one cycle after `o_addr`.
- `o_wstb`  output  1  child write strobe, registered.

## Operation
- Every cycle the block samples `i_addr`, `i_wdata` and `i_wstb`.
- hit = (`i_addr[AW-1:CHILD_AW]` == `BASE[AW-1:CHILD_AW]`). When CHILD_AW == AW, hit is always 1.
- `o_addr` = {zeros, `i_addr[CHILD_AW-1:0]`}, so the upper bits are always 0.
- `o_wdata` = `i_wdata`, forwarded unconditionally.
- `o_wstb` = `i_wstb` & hit.
- Reads: any cycle counts as a read address. The hit flag is delayed 2 stages so it aligns with the returning data.
- `i_rdata` is registered every cycle:
  - delayed hit = 1: `i_rdata` = `o_rdata`.
  - delayed hit = 0: `i_rdata` = 0.
- Back-to-back strobes are forwarded back-to-back. There is no backpressure and no buffering.
- Reset takes priority over everything else. While `i_rst` is high:
  - `o_addr`, `o_wdata`, `o_wstb`, `i_rdata` and both delayed-hit flags are cleared to 0.
  - Any strobe in flight is dropped; no write reaches the child after the reset edge.
- Reset values: every registered output is 0. `o_clk` follows `i_clk` at all times.

## Timing
- A parent request is sampled at edge k. `o_addr`, `o_wdata` and `o_wstb` are valid after edge k. Write latency is 1 cycle.
- `o_wstb` stays high for exactly one cycle per qualifying parent strobe.
- The child drives `o_rdata` after edge k+1, and the bridge captures it at edge k+2.
- `i_rdata` for the address sampled at edge k is valid after edge k+2, i.e. the parent samples it at edge k+3. Read latency is 3.
- Window boundaries: BASE and BASE+2^CHILD_AW−1 hit; BASE−1 and BASE+2^CHILD_AW miss.
- If a reset is asserted during a read, `i_rdata` reads 0 until 3 cycles after reset is released.

## Configuration
- `BUS_GLUE_WINDOW_EN` defined: window decode, address trim, strobe gating and out-of-window zero read data, all as described above.
- `BUS_GLUE_WINDOW_EN` undefined: hit is forced to 1.
  - `o_addr` = `i_addr` untrimmed, and `o_wstb` = `i_wstb`.
  - `i_rdata` is always the captured `o_rdata`.
  - `CHILD_AW` and `BASE` are unused.
  - Latencies are unchanged.

## Test plan
Setup: AW=24, DW=32, CHILD_AW=8, BASE=0x000100. The child model registers rdata one cycle after `o_addr`; address 0x01 returns 0xbeefca5e.

- Reset: hold `i_rst`=1 for 2 cycles with `i_wstb`=1 and `i_addr`=0x000105 → `o_wstb`=0, `o_addr`=0, `i_rdata`=0 throughout.
- Write `i_addr`=0x000105, `i_wdata`=0xdeadbeef for 1 cycle → one cycle later `o_addr`=0x000005, `o_wdata`=0xdeadbeef, `o_wstb`=1 for exactly one cycle.
- Out-of-window write to 0x000205:
  - With macro → `o_wstb` stays 0.
  - Without macro → `o_addr`=0x000205, `o_wstb`=1.
- Read 0x000101 → `i_rdata`=0xbeefca5e at the 3rd edge after sampling.
- Read 0x0000ff (with macro) → `i_rdata`=0.
- Back-to-back writes to 0x000100 then 0x0001ff → `o_wstb` high on two consecutive cycles with `o_addr`=0x00 then 0xff.
- Write 0x000200 → no strobe (boundary miss).
- Assert `i_rst` on the same edge a write to 0x000110 is sampled → `o_wstb` never rises.
- Release reset → next write to 0x000110 forwards normally.

Source files
------------

// File: rtl/bus_glue_bridge.sv
// bus_glue_bridge: registered single-clock bridge from a parent local bus to a
// child local bus. Forwards writes/reads into a child address window and returns
// child read data to the parent with a fixed 3-cycle read latency.
//
// Optional feature macro: BUS_GLUE_WINDOW_EN
//   defined   -> window decode, address trim, strobe gating, zero read data on miss
//   undefined -> every access hits; address passed through untrimmed
module bus_glue_bridge #(
  parameter int unsigned    AW       = 24,
  parameter int unsigned    DW       = 32,
  parameter int unsigned    CHILD_AW = 22,
  parameter logic [AW-1:0]  BASE     = '0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_wstb,
  output logic [DW-1:0] i_rdata,
  output logic          o_clk,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_wdata,
  input  logic [DW-1:0] o_rdata,
  output logic          o_wstb
);

  // Low CHILD_AW bits select a word inside the window; the rest must match BASE.
  // A mask avoids zero-width slices when CHILD_AW == AW (whole space is the window).
  localparam logic [AW-1:0] WIN_MASK =
    (CHILD_AW >= AW) ? {AW{1'b1}} : AW'(({{(AW-1){1'b0}}, 1'b1} << CHILD_AW) - 1'b1);

  logic          hit;
  logic [AW-1:0] addr_d, addr_q;
  logic [DW-1:0] wdata_q;
  logic          wstb_d, wstb_q;
  logic [2:1]    hit_pipe_q;   // hit delayed two stages to line up with child rdata
  logic [DW-1:0] rdata_d, rdata_q;

  // Window decode, address trim and strobe gating for the sampled request.
`ifdef BUS_GLUE_WINDOW_EN
  always_comb begin
    hit    = (((i_addr ^ BASE) & ~WIN_MASK) == '0);
    addr_d = i_addr & WIN_MASK;
    wstb_d = i_wstb & hit;
  end
`else
  always_comb begin
    hit    = 1'b1;
    addr_d = i_addr;
    wstb_d = i_wstb;
  end
`endif

  // Returned child data is passed through only for in-window reads.
  always_comb begin
    rdata_d = hit_pipe_q[2] ? o_rdata : '0;
  end

  // Request, hit pipeline and read-data registers; reset drops anything in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      wstb_q     <= 1'b0;
      hit_pipe_q <= '0;
      rdata_q    <= '0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= i_wdata;
      wstb_q     <= wstb_d;
      hit_pipe_q <= {hit_pipe_q[1], hit};
      rdata_q    <= rdata_d;
    end
  end

  assign o_clk   = i_clk;
  assign o_addr  = addr_q;
  assign o_wdata = wdata_q;
  assign o_wstb  = wstb_q;
  assign i_rdata = rdata_q;

endmodule

// File: tb/tb_bus_glue_bridge.sv
// Directed bench for bus_glue_bridge: AW=24, DW=32, CHILD_AW=8, BASE=0x000100.
// Expected values depend on whether BUS_GLUE_WINDOW_EN is defined for the build.
module tb_bus_glue_bridge;

`ifdef BUS_GLUE_WINDOW_EN
  localparam bit WIN = 1'b1;
`else
  localparam bit WIN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic        wstb;
  logic [31:0] rdata;
  logic        oclk;
  logic [23:0] oaddr;
  logic [31:0] owdata;
  logic [31:0] ordata = 32'h0;
  logic        owstb;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_glue_bridge #(.AW(24), .DW(32), .CHILD_AW(8), .BASE(24'h000100)) dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wdata(wdata), .i_wstb(wstb),
    .i_rdata(rdata), .o_clk(oclk), .o_addr(oaddr), .o_wdata(owdata),
    .o_rdata(ordata), .o_wstb(owstb)
  );

  // Child: registers read data one cycle after o_addr; word 0x01 holds 0xbeefca5e,
  // other words return 0xc0ffee followed by the low address byte.
  always @(posedge clk)
    ordata <= (oaddr[7:0] == 8'h01) ? 32'hbeefca5e : {24'hc0ffee, oaddr[7:0]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read data seen for parent address 0x0000ff (one below the window).
  localparam logic [31:0] RD_FF = WIN ? 32'h0 : 32'hc0ffeeff;

  initial begin
    // Reset held two cycles with a write pending.
    rst = 1'b1; wstb = 1'b1; addr = 24'h000105; wdata = 32'h11111111;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_wstb",  32'(owstb), 32'h0);
      chk("rst_addr",  32'(oaddr), 32'h0);
      chk("rst_wdata", owdata,     32'h0);
      chk("rst_rdata", rdata,      32'h0);
    end
    chk("o_clk", 32'(oclk), 32'h1);
    rst = 1'b0; wstb = 1'b0; addr = 24'h0000ff; wdata = 32'h0;
    tick();

    // In-window write.
    addr = 24'h000105; wdata = 32'hdeadbeef; wstb = 1'b1;
    tick();
    chk("wr_addr",  32'(oaddr), WIN ? 32'h000005 : 32'h000105);
    chk("wr_wdata", owdata,     32'hdeadbeef);
    chk("wr_wstb",  32'(owstb), 32'h1);
    wstb = 1'b0; addr = 24'h0000ff;
    tick();
    chk("wr_wstb_1cyc", 32'(owstb), 32'h0);

    // Out-of-window write.
    addr = 24'h000205; wstb = 1'b1;
    tick();
    chk("oow_wstb", 32'(owstb), WIN ? 32'h0 : 32'h1);
    chk("oow_addr", 32'(oaddr), WIN ? 32'h000005 : 32'h000205);
    wstb = 1'b0; addr = 24'h0000ff;
    tick();
    chk("oow_wstb_off", 32'(owstb), 32'h0);

    // Single-cycle read of 0x000101 surrounded by reads of 0x0000ff.
    addr = 24'h000101;
    tick();                              // edge k samples 0x101
    addr = 24'h0000ff;
    chk("rd_addr", 32'(oaddr), WIN ? 32'h000001 : 32'h000101);
    tick();                              // k+1: still data for 0xff
    chk("rd_early", rdata, RD_FF);
    tick();                              // k+2: data for 0x101
    chk("rd_data", rdata, 32'hbeefca5e);
    tick();                              // k+3: data for 0xff (below window)
    chk("rd_miss", rdata, RD_FF);

    // Back-to-back writes at both window edges.
    addr = 24'h000100; wstb = 1'b1;
    tick();
    chk("b2b0_wstb", 32'(owstb), 32'h1);
    chk("b2b0_addr", 32'(oaddr), WIN ? 32'h000000 : 32'h000100);
    addr = 24'h0001ff;
    tick();
    chk("b2b1_wstb", 32'(owstb), 32'h1);
    chk("b2b1_addr", 32'(oaddr), WIN ? 32'h0000ff : 32'h0001ff);
    wstb = 1'b0; addr = 24'h0000ff;
    tick();
    chk("b2b_off", 32'(owstb), 32'h0);

    // One past the window top.
    addr = 24'h000200; wstb = 1'b1;
    tick();
    chk("bnd_wstb", 32'(owstb), WIN ? 32'h0 : 32'h1);
    wstb = 1'b0; addr = 24'h0000ff;
    tick();

    // Reset sampled on the same edge as a write; rdata held 0 after release.
    addr = 24'h000110; wdata = 32'h12345678; wstb = 1'b1; rst = 1'b1;
    tick();
    chk("rstw_wstb",  32'(owstb), 32'h0);
    chk("rstw_addr",  32'(oaddr), 32'h0);
    chk("rstw_rdata", rdata,      32'h0);
    rst = 1'b0; wstb = 1'b0; addr = 24'h000101;
    tick();                              // edge r samples 0x101
    addr = 24'h0000ff;
    chk("rel_wstb",   32'(owstb), 32'h0);
    chk("rel_rdata0", rdata, 32'h0);
    tick();
    chk("rel_rdata1", rdata, 32'h0);
    tick();
    chk("rel_rdata2", rdata, 32'hbeefca5e);

    // Write after reset release forwards normally.
    addr = 24'h000110; wdata = 32'hcafef00d; wstb = 1'b1;
    tick();
    chk("post_wstb",  32'(owstb), 32'h1);
    chk("post_addr",  32'(oaddr), WIN ? 32'h000010 : 32'h000110);
    chk("post_wdata", owdata,     32'hcafef00d);
    wstb = 1'b0;
    tick();
    chk("post_off", 32'(owstb), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
